mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data and address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 1..15: memory access cycles per transaction.
REQ-003 SHALL have parameter D_BURST_MAX, default 4, legal range 1..7: maximum consecutive data grants while an instruction request is pending.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: if_req  in  1, if_addr  in  WIDTH; instruction-fetch request and address.
REQ-007 SHALL have ports: if_rdata  out  WIDTH, if_ready  out  1; fetched word and one-cycle completion strobe.
REQ-008 SHALL have ports: d_req  in  1, d_we  in  1, d_addr  in  WIDTH, d_wdata  in  WIDTH, d_funct3  in  3; data load/store request.
REQ-009 SHALL have ports: d_rdata  out  WIDTH, d_ready  out  1; load data and one-cycle completion strobe.
REQ-010 SHALL have ports: mem_en  out  1, mem_we  out  1, mem_addr  out  WIDTH, mem_wdata  out  WIDTH, mem_funct3  out  3; single-port memory command.
REQ-011 SHALL have port: mem_rdata  in  WIDTH; memory read data, valid in the last BUSY cycle.

Function
REQ-012 SHALL implement the states IDLE, BUSY and DONE, plus a 1-bit owner register (I or D).
REQ-013 In IDLE with a request present, the block SHALL grant, latch the granted address, wdata, we and funct3 into command registers, load wait_cnt=WAIT_CYCLES-1, and go to BUSY.
REQ-014 Grant priority SHALL be D over I, except when d_cnt==D_BURST_MAX and if_req=1; in that case I is granted.
REQ-015 d_cnt SHALL increment, saturating at D_BURST_MAX, on each D grant. It SHALL clear to 0 on each I grant.
REQ-016 An I grant SHALL force the latched we=0 and funct3=3'b010.
REQ-017 In BUSY, mem_en SHALL be 1, mem_we SHALL equal the latched we, and mem_addr, mem_wdata and mem_funct3 SHALL be held at the latched values. wait_cnt SHALL decrement each cycle.
REQ-018 In BUSY with wait_cnt==0, the block SHALL register mem_rdata into the owner's rdata register (loads and fetches only) and go to DONE.
REQ-019 In DONE, exactly the owner's ready SHALL be 1 for one cycle and mem_en SHALL be 0. The next state SHALL be IDLE unconditionally, with no grant in DONE.
REQ-020 Latency: request seen in IDLE at cycle T -> ready at cycle T+WAIT_CYCLES+1. Back-to-back throughput SHALL be one transaction per WAIT_CYCLES+2 cycles.
REQ-021 Requesters hold req and payload stable until their ready. Changes to req or payload while not in IDLE SHALL be ignored.
REQ-022 On a store, d_rdata SHALL keep its previous value. d_ready SHALL still pulse.
REQ-023 if_rdata and d_rdata SHALL be stable between updates, and each SHALL change only when its own transaction completes.
REQ-024 Outside BUSY, mem_en and mem_we SHALL be 0. The mem_addr, mem_wdata and mem_funct3 outputs SHALL hold their last latched values.
REQ-025 Simultaneous if_req and d_req in IDLE SHALL produce exactly one grant per REQ-014. The losing request SHALL remain pending and SHALL be granted in the next IDLE if it is still asserted.

Reset
REQ-026 While rst=0, the block SHALL be in IDLE with wait_cnt=0, d_cnt=0, owner=I, if_ready=0, d_ready=0, mem_en=0, mem_we=0, and if_rdata, d_rdata, mem_addr, mem_wdata, mem_funct3 all 0.
REQ-027 Reset asserted mid-transaction SHALL abort it immediately (asynchronously) with no ready pulse. After release, pending requests SHALL be regranted from IDLE.

Verification
REQ-028 Scenario: WAIT_CYCLES=2, if_req=1, if_addr=0x10, mem_rdata=0x00500093 in the last BUSY cycle -> mem_en high for 2 cycles with mem_we=0, if_ready at T+3, if_rdata=0x00500093.
REQ-029 Scenario: if_req and d_req rise together, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, funct3=010 -> D granted first with mem_we=1 and mem_wdata=0xDEADBEEF; d_ready at T+3 and d_rdata unchanged; I granted at T+4 and if_ready at T+7.
REQ-030 Scenario: d_req held high continuously for 6 loads with if_req high, D_BURST_MAX=4 -> grant order D,D,D,D,I,D and d_cnt=0 after the I grant.
REQ-031 Scenario: rst driven low during the second BUSY cycle of a load -> mem_en=0 within the same cycle, no d_ready, all outputs 0; after release with d_req held, the load completes WAIT_CYCLES+1 cycles after the first IDLE cycle.
REQ-032 Scenario: WAIT_CYCLES=1, alternating single I and D requests -> each ready 2 cycles after its grant, with exactly one DONE cycle between transactions.
REQ-033 Scenario: d_addr changed from 0x40 to 0x44 during BUSY -> mem_addr stays 0x40 until DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) arbiter for a single-port memory
module mem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int D_BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_ready,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    input  logic [2:0]       d_funct3,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [2:0]       mem_funct3,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [2:0] BURST_MAX = 3'(D_BURST_MAX);

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic [2:0]       d_cnt;
    logic             owner;
    logic             cmd_we;
    logic [WIDTH-1:0] cmd_addr;
    logic [WIDTH-1:0] cmd_wdata;
    logic [2:0]       cmd_funct3;
    logic [WIDTH-1:0] if_rdata_q;
    logic [WIDTH-1:0] d_rdata_q;
    logic             i_wins;
    logic             d_wins;

    // Data normally wins; a full data burst yields one slot to a waiting fetch.
    always_comb begin
        i_wins = if_req && (!d_req || (d_cnt == BURST_MAX));
        d_wins = d_req && !i_wins;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            d_cnt      <= '0;
            owner      <= OWN_I;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_funct3 <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_wins) begin
                        owner      <= OWN_I;
                        cmd_we     <= 1'b0;
                        cmd_addr   <= if_addr;
                        cmd_wdata  <= '0;
                        cmd_funct3 <= 3'b010;
                        d_cnt      <= '0;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= S_BUSY;
                    end else if (d_wins) begin
                        owner      <= OWN_D;
                        cmd_we     <= d_we;
                        cmd_addr   <= d_addr;
                        cmd_wdata  <= d_wdata;
                        cmd_funct3 <= d_funct3;
                        d_cnt      <= (d_cnt == BURST_MAX) ? d_cnt : d_cnt + 3'd1;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_DONE;
                        if (owner == OWN_I) begin
                            if_rdata_q <= mem_rdata;
                        end else if (!cmd_we) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_en     = (state == S_BUSY);
        mem_we     = (state == S_BUSY) && cmd_we;
        mem_addr   = cmd_addr;
        mem_wdata  = cmd_wdata;
        mem_funct3 = cmd_funct3;
        if_ready   = (state == S_DONE) && (owner == OWN_I);
        d_ready    = (state == S_DONE) && (owner == OWN_D);
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a timeline-based reference model
module tb_mem_arbiter;

    localparam int W = 2;
    localparam int B = 4;
    localparam logic [31:0] IA = 32'h100;
    localparam logic [31:0] DA = 32'h200;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    mem_arbiter #(.WIDTH(32), .WAIT_CYCLES(W), .D_BURST_MAX(B)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h00500093;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = rd_fn(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction granted at edge g is busy for edges g..g+W-1,
    // done at g+W, and the arbiter is free again from g+W+1 on.
    int          m_e, m_g, n;
    bit          m_act, m_own_d, m_we, busy, done, idle;
    int          m_dcnt;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    logic [2:0]  m_f3;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act = 0; m_e = 0; m_g = 0; m_dcnt = 0; m_own_d = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_f3 = 0; m_ifr = 0; m_dr = 0;
        end else begin
            n = m_e - m_g;
            idle = !m_act || (n > W);
            if (m_act && n == W - 1) begin
                if (!m_own_d) m_ifr = rd_fn(m_addr);
                else if (!m_we) m_dr = rd_fn(m_addr);
            end
            m_e++;
            if (idle && (if_req || d_req)) begin
                if (if_req && (!d_req || m_dcnt == B)) begin
                    m_own_d = 0; m_we = 0; m_addr = if_addr; m_wdata = 0; m_f3 = 3'b010;
                    m_dcnt = 0;
                end else begin
                    m_own_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_f3 = d_funct3;
                    if (m_dcnt < B) m_dcnt++;
                end
                m_act = 1;
                m_g = m_e;
            end
        end
        #1;
        n = m_e - m_g;
        busy = m_act && (n < W);
        done = m_act && (n == W);
        check("mem_en", 32'(mem_en), 32'(busy));
        check("mem_we", 32'(mem_we), 32'(busy && m_we));
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_funct3", 32'(mem_funct3), 32'(m_f3));
        check("if_ready", 32'(if_ready), 32'(done && !m_own_d));
        check("d_ready", 32'(d_ready), 32'(done && m_own_d));
        check("if_rdata", if_rdata, m_ifr);
        check("d_rdata", d_rdata, m_dr);
    end

    logic [31:0] gaddr [0:7];
    int          gcount;
    logic [31:0] exp30 [0:5] = '{DA, DA, DA, DA, IA, DA};

    task automatic wait_rdy(input bit is_d, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (is_d ? d_ready : if_ready) begin
                at = cyc;
                break;
            end
        end
        check(is_d ? "d_ready_seen" : "if_ready_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic collect(input int cnt, input int budget);
        logic prev;
        gcount = 0;
        prev = mem_en;
        for (int k = 0; k < budget && gcount < cnt; k++) begin
            @(posedge clk); #1;
            if (mem_en && !prev) begin
                gaddr[gcount] = mem_addr;
                gcount++;
            end
            prev = mem_en;
        end
        check("grant_count", 32'(gcount), 32'(cnt));
    endtask

    int t0, at;

    initial begin
        rst = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_funct3 = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        rst = 1;
        repeat (2) @(negedge clk);

        // single fetch
        if_req = 1; if_addr = 32'h10; t0 = cyc;
        @(posedge clk); #1;
        check("s28_mem_en", 32'(mem_en), 32'd1);
        check("s28_mem_we", 32'(mem_we), 32'd0);
        check("s28_mem_addr", mem_addr, 32'h10);
        wait_rdy(0, 10, at);
        check("s28_latency", 32'(at - t0), 32'd3);
        check("s28_if_rdata", if_rdata, 32'h00500093);
        @(negedge clk); if_req = 0;
        repeat (2) @(negedge clk);

        // simultaneous fetch and store
        if_req = 1; if_addr = 32'h30;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
        t0 = cyc;
        @(posedge clk); #1;
        check("s29_mem_we", 32'(mem_we), 32'd1);
        check("s29_mem_wdata", mem_wdata, 32'hDEADBEEF);
        wait_rdy(1, 10, at);
        check("s29_d_latency", 32'(at - t0), 32'd3);
        check("s29_d_rdata", d_rdata, 32'd0);
        @(negedge clk); d_req = 0; d_we = 0;
        wait_rdy(0, 10, at);
        check("s29_i_latency", 32'(at - t0), 32'd7);
        @(negedge clk); if_req = 0;
        repeat (2) @(negedge clk);

        // data burst limit with a waiting fetch
        if_req = 1; if_addr = IA; d_req = 1; d_we = 0; d_addr = DA; d_funct3 = 3'b010;
        collect(6, 60);
        for (int i = 0; i < 6; i++) check($sformatf("s30_grant%0d", i), gaddr[i], exp30[i]);
        @(negedge clk); if_req = 0; d_req = 0;
        repeat (6) @(negedge clk);

        // d_cnt saturates while no fetch waits, so a late fetch wins at once
        d_req = 1;
        collect(5, 40);
        for (int i = 0; i < 5; i++) check($sformatf("s30b_grant%0d", i), gaddr[i], DA);
        @(negedge clk); if_req = 1;
        collect(1, 20);
        check("s30b_fetch_grant", gaddr[0], IA);
        wait_rdy(0, 10, at);
        @(negedge clk); if_req = 0; d_req = 0;
        repeat (2) @(negedge clk);

        // payload change during BUSY is ignored
        d_req = 1; d_we = 0; d_addr = 32'h40;
        @(posedge clk); #1;
        @(negedge clk); d_addr = 32'h44;
        wait_rdy(1, 10, at);
        check("s33_mem_addr", mem_addr, 32'h40);
        check("s33_d_rdata", d_rdata, 32'h0040FFBF);
        @(negedge clk); d_req = 0;
        repeat (2) @(negedge clk);

        // store keeps previous load data
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678; d_funct3 = 3'b000;
        wait_rdy(1, 10, at);
        check("store_d_rdata", d_rdata, 32'h0040FFBF);
        @(negedge clk); d_req = 0; d_we = 0;
        repeat (2) @(negedge clk);

        // reset in the second BUSY cycle of a load
        d_req = 1; d_addr = 32'h60; d_funct3 = 3'b010;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 0;
        #1;
        check("s31_mem_en", 32'(mem_en), 32'd0);
        check("s31_d_ready", 32'(d_ready), 32'd0);
        check("s31_mem_addr", mem_addr, 32'd0);
        check("s31_d_rdata", d_rdata, 32'd0);
        @(negedge clk); rst = 1; t0 = cyc;
        wait_rdy(1, 10, at);
        check("s31_latency", 32'(at - t0), 32'd3);
        check("s31_d_rdata_after", d_rdata, 32'h0060FF9F);
        @(negedge clk); d_req = 0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
